// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: redirect-source encoding, reset/NOP
// constants and the IF/ID record carried between fetch and decode.
package mips_pkg;

  localparam int XLEN = 32;

  // Redirect source selected by the ID-stage controller when PCsrc is set.
  typedef enum logic [1:0] {
    JSEL_BRANCH = 2'b00,
    JSEL_JUMP   = 2'b01,
    JSEL_JR     = 2'b10,
    JSEL_RSVD   = 2'b11
  } jsel_e;

  // sll $0,$0,0 -- the canonical bubble.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Stall holds every field; flush loads a bubble
// (NOP, valid=0) but still captures pc+4 so the record stays well formed.
// stall has priority over flush.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_VALUE = mips_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t reg_q;

  // Hold on stall, bubble on flush, otherwise capture the fetched record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q.instr    <= NOP_VALUE;
      reg_q.pc_plus4 <= '0;
      reg_q.valid    <= 1'b0;
    end else if (stall_i) begin
      reg_q <= reg_q;
    end else if (flush_i) begin
      reg_q.instr    <= NOP_VALUE;
      reg_q.pc_plus4 <= d_i.pc_plus4;
      reg_q.valid    <= 1'b0;
    end else begin
      reg_q <= d_i;
    end
  end

  assign q_o = reg_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection and the IF/ID register.
// Control contract with ID/hazard unit: stall is level-sensitive and wins
// over everything; a redirect (PCsrc) or flush (clr) presented during a
// stalled cycle is dropped and must be re-presented by ID once stall falls.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            PCsrc,
  input  logic [1:0]      jsel,
  input  logic            clr,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic            valid_id,
  output logic            PCinit
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            pcinit_q;
  logic            armed_q;
  logic            redirect;
  logic            flush;
  if_id_t          if_id_d, if_id_q;

  // Target bits [1:0] are forced to zero, so they are deliberately dropped.
  logic unused_lsbs;
  assign unused_lsbs = ^{branch_target[1:0], jr_target[1:0]};

  // 32-bit add wraps FFFF_FFFC -> 0 naturally.
  assign pc_plus4 = pc_q + 32'd4;

  // While PCinit is high the controller's outputs are not yet meaningful.
  assign redirect = PCsrc & ~pcinit_q;
  assign flush    = clr & ~pcinit_q;

  // Next-PC selection: stall holds, redirect picks a target, else sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (stall) begin
      pc_d = pc_q;
    end else if (redirect) begin
      case (jsel)
        JSEL_BRANCH: pc_d = {branch_target[XLEN-1:2], 2'b00};
        JSEL_JUMP:   pc_d = {if_id_q.pc_plus4[XLEN-1:28], if_id_q.instr[25:0], 2'b00};
        JSEL_JR:     pc_d = {jr_target[XLEN-1:2], 2'b00};
        default:     pc_d = pc_plus4;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // PCinit: high out of reset, survives the first edge, clears on the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcinit_q <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (armed_q) pcinit_q <= 1'b0;
    end
  end

  always_comb begin
    if_id_d          = '0;
    if_id_d.instr    = imem_rdata;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.valid    = 1'b1;
  end

  if_id_reg #(
    .NOP_VALUE (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .flush_i (flush),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

  assign imem_addr   = pc_q;
  assign instr_id    = if_id_q.instr;
  assign pc_plus4_id = if_id_q.pc_plus4;
  assign valid_id    = if_id_q.valid;
  assign PCinit      = pcinit_q;

endmodule
